// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access sequencer: access sizes, FSM states
// and the alignment rule applied when a request is accepted.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        WORDop = 2'b00,
        HALFop = 2'b01,
        BYTEop = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    // Encoding 2'b11 is not a legal size and is reported like a misalignment.
    function automatic logic misaligned(input logic [1:0] op, input logic [1:0] lo);
        logic bad;
        case (op)
            WORDop:  bad = (lo != 2'b00);
            HALFop:  bad = lo[0];
            BYTEop:  bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ld_align.sv
// Load extraction: selects the addressed byte/half of a raw memory word and
// sign- or zero-extends it to 32 bits.
module ld_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  op,
    input  logic        sext,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw[7:0];
        case (addr_lo)
            2'd0:    byte_v = raw[7:0];
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            default: byte_v = raw[31:24];
        endcase
        half_v = addr_lo[1] ? raw[31:16] : raw[15:0];

        result = raw;
        case (op)
            BYTEop:  result = {{24{sext & byte_v[7]}}, byte_v};
            HALFop:  result = {{16{sext & half_v[15]}}, half_v};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer: alignment check, byte-enable and store-lane
// generation, req/ack memory handshake with timeout, extended load return.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  op,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [29:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    op_q, op_d;
    logic          sext_q, sext_d;
    logic [1:0]    lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [29:0]   m_addr_q, m_addr_d;
    logic [3:0]    m_be_q, m_be_d;
    logic [31:0]   m_wdata_q, m_wdata_d;

    logic [3:0]    be_new;
    logic [31:0]   wdata_rep;
    logic [31:0]   ld_data;

    ld_align u_ld_align (
        .raw     (m_rdata),
        .addr_lo (lo_q),
        .op      (op_q),
        .sext    (sext_q),
        .result  (ld_data)
    );

    // Lane controls are computed from the live request so they can be
    // registered on the accepting edge and held stable through ISSUE.
    always_comb begin
        be_new    = '0;
        wdata_rep = wdata;
        case (op)
            WORDop: be_new = 4'b1111;
            HALFop: begin
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            BYTEop: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            default: be_new = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        op_d      = op_q;
        sext_d    = sext_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_be_d    = m_be_q;
        m_wdata_d = m_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d   = we;
                    op_d   = op;
                    sext_d = sext;
                    lo_d   = addr[1:0];
                    cnt_d  = '0;
                    if (misaligned(op, addr[1:0])) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        err_d     = 1'b0;
                        m_req_d   = 1'b1;
                        m_we_d    = we;
                        m_addr_d  = addr[31:2];
                        m_be_d    = be_new;
                        m_wdata_d = wdata_rep;
                    end
                end
            end
            S_ISSUE: begin
                // Ack is tested first so it beats a simultaneous timeout.
                if (m_ack || (cnt_q + CW'(1) == CW'(TIMEOUT))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = ~m_ack;
                    cnt_d   = '0;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    m_be_d  = '0;
                    if (m_ack && !we_q) begin
                        rdata_d = ld_data;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            op_q      <= '0;
            sext_q    <= 1'b0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_be_q    <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            op_q      <= op_d;
            sext_q    <= sext_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_be_q    <= m_be_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_be    = m_be_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level reference timeline driven
// alongside the stimulus, compared against the DUT on every falling edge.
module tb_mem_access_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst, req, we, sext, m_ack;
    logic [1:0]  op;
    logic [31:0] addr, wdata, m_rdata;
    logic        busy, done, err, m_req, m_we;
    logic [31:0] rdata, m_wdata;
    logic [29:0] m_addr;
    logic [3:0]  m_be;

    mem_access_ctrl #(.TIMEOUT(TMO), .CW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .op(op), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_be(m_be), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        cmp_en = 1'b0;
    logic        exp_busy, exp_done, exp_err, exp_mreq, exp_mwe;
    logic [29:0] exp_maddr;
    logic [3:0]  exp_mbe;
    logic [31:0] exp_mwdata, exp_rdata;
    logic [3:0]  obs_be;
    logic [29:0] obs_addr;
    logic [31:0] obs_wd;
    logic        obs_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference rules, stated arithmetically.
    function automatic int unsigned sz(input logic [1:0] o);
        return (o == 2'd0) ? 4 : (o == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic mdl_mis(input logic [1:0] o, input logic [31:0] a);
        if (o == 2'd3) return 1'b1;
        return (a % sz(o)) != 0;
    endfunction

    function automatic logic [3:0] mdl_be(input logic [1:0] o, input logic [31:0] a);
        int unsigned mask = (1 << sz(o)) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] mdl_wd(input logic [1:0] o, input logic [31:0] w);
        if (o == 2'd2) return (w & 32'hFF) * 32'h01010101;
        if (o == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] mdl_ld(input logic [1:0] o, input logic [31:0] a,
                                           input logic s, input logic [31:0] raw);
        int unsigned bits = 8 * sz(o);
        logic [31:0] mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 1);
        logic [31:0] v    = (raw >> (8 * (a % 4))) & mask;
        if (s && bits < 32 && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("m_req", 32'(m_req), 32'(exp_mreq));
            chk("m_be", 32'(m_be), 32'(exp_mbe));
            chk("rdata", rdata, exp_rdata);
            if (exp_done) chk("err", 32'(err), 32'(exp_err));
            if (exp_mreq) begin
                chk("m_we", 32'(m_we), 32'(exp_mwe));
                chk("m_addr", 32'(m_addr), 32'(exp_maddr));
                chk("m_wdata", m_wdata, exp_mwdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_mreq = 1'b0; exp_mbe  = '0;
    endtask

    // dly = number of ISSUE cycles without ack before ack; >= TMO means never.
    task automatic do_access(input logic w, input logic [1:0] o, input logic s,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int dly, input logic [31:0] raw);
        req = 1'b1; we = w; op = o; sext = s; addr = a; wdata = wd;
        m_ack = 1'($urandom_range(0, 1)); m_rdata = $urandom;
        step();
        obs_be = m_be; obs_addr = m_addr; obs_wd = m_wdata; obs_we = m_we;
        req = 1'($urandom_range(0, 1)); we = 1'($urandom); op = 2'($urandom);
        sext = 1'($urandom); addr = $urandom; wdata = $urandom;
        if (mdl_mis(o, a)) begin
            exp_busy = 1'b1; exp_done = 1'b1; exp_err = 1'b1;
            exp_mreq = 1'b0; exp_mbe = '0;
            m_ack = 1'($urandom);
            step();
            set_idle();
            req = 1'b0;
            return;
        end
        exp_busy = 1'b1; exp_done = 1'b0; exp_mreq = 1'b1; exp_mwe = w;
        exp_maddr = a[31:2]; exp_mbe = mdl_be(o, a); exp_mwdata = mdl_wd(o, wd);
        for (int k = 0; k < TMO; k++) begin
            m_ack   = (k == dly);
            m_rdata = (k == dly) ? raw : $urandom;
            req     = 1'($urandom_range(0, 1));
            step();
            if (k == dly || k == TMO - 1) begin
                exp_mreq = 1'b0; exp_mbe = '0; exp_done = 1'b1;
                exp_err  = (k != dly);
                if (k == dly && !w) exp_rdata = mdl_ld(o, a, s, raw);
                m_ack = 1'($urandom);
                step();
                set_idle();
                break;
            end
        end
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; op = '0; sext = 1'b0;
        addr = '0; wdata = '0; m_ack = 1'b0; m_rdata = '0;
        set_idle();
        exp_rdata = '0; exp_mwe = 1'b0; exp_maddr = '0; exp_mwdata = '0;
        step();
        cmp_en = 1'b1;
        chk("rst_m_addr", 32'(m_addr), 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        step();
        rst = 1'b0;
        step();

        do_access(1'b1, 2'd0, 1'b0, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        chk("word_st_be", 32'(obs_be), 32'hF);
        chk("word_st_addr", 32'(obs_addr), 32'h40);
        chk("word_st_we", 32'(obs_we), 32'h1);

        do_access(1'b0, 2'd2, 1'b1, 32'h203, 32'h0, 0, 32'h80112233);
        chk("byte_ld_be", 32'(obs_be), 32'h8);
        chk("byte_ld_sext", rdata, 32'hFFFFFF80);
        do_access(1'b0, 2'd2, 1'b0, 32'h203, 32'h0, 0, 32'h80112233);
        chk("byte_ld_zext", rdata, 32'h00000080);

        do_access(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 0, 32'h0);
        chk("half_st_be", 32'(obs_be), 32'hC);
        chk("half_st_wd", obs_wd, 32'hABCDABCD);
        do_access(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 0, 32'h0);
        chk("misal_keep_rdata", rdata, 32'h00000080);

        do_access(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 5, 32'h8001_7FFF);
        chk("wait_ld_half", rdata, 32'hFFFF8001);

        do_access(1'b0, 2'd0, 1'b0, 32'h80, 32'h0, 99, 32'h0);
        chk("tmo_keep_rdata", rdata, 32'hFFFF8001);
        do_access(1'b0, 2'd0, 1'b0, 32'h84, 32'h0, TMO - 1, 32'h1234_5678);
        chk("ack_at_tmo", rdata, 32'h12345678);

        // Reset during the third wait cycle abandons the access.
        req = 1'b1; we = 1'b0; op = 2'd0; sext = 1'b0; addr = 32'h300; m_ack = 1'b0;
        step();
        req = 1'b0;
        exp_busy = 1'b1; exp_mreq = 1'b1; exp_mwe = 1'b0;
        exp_maddr = 30'hC0; exp_mbe = 4'hF; exp_mwdata = mdl_wd(2'd0, wdata);
        step();
        step();
        rst = 1'b1;
        step();
        set_idle();
        exp_rdata = '0;
        rst = 1'b0;
        step();
        do_access(1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 1, 32'hAABBCCDD);
        chk("after_rst_ld", rdata, 32'h000000CC);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  o;
            int          d;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'(a[1:0] & ~(sz(2'($urandom)) - 1));
            o = 2'($urandom_range(0, 3) == 0 ? 3 : $urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0:       d = TMO - 1;
                1:       d = TMO + 3;
                default: d = $urandom_range(0, 6);
            endcase
            do_access(1'($urandom), o, 1'($urandom), a, $urandom, d, $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                m_ack = 1'($urandom);
                step();
            end
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
